// File: rtl/morse_pkg.sv
// Shared types and constants for the Morse symbol framer.
// Holds the FSM state encoding, symbol bit values and the default code-word capacity.
package morse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MARK  = 2'd1,
        SPACE = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic SYM_DOT  = 1'b0;
    localparam logic SYM_DASH = 1'b1;

    localparam int MAX_SYMBOLS_DEF = 5;

endpackage

// File: rtl/morse_symbol_framer_sync.sv
// Two-flop synchronizer followed by a registered rise/fall detector.
// A pin edge shows up as a one-clk pulse three clocks later.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic stable;
    logic prev;

    // NOTE: sequential state uses non-blocking assignments so each flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta   <= 1'b0;
            stable <= 1'b0;
            prev   <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            meta   <= din;
            stable <= meta;
            prev   <= stable;
            rise   <= stable & ~prev;
            fall   <= ~stable & prev;
        end
    end

endmodule

// File: rtl/morse_symbol_framer.sv
// Times key marks/spaces in divided-clock units, classifies dot/dash and
// frames each letter into a code word with valid, error and word-gap strobes.
module morse_symbol_framer
    import morse_pkg::*;
#(
    parameter int DASH_UNITS       = 3,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int WORD_GAP_UNITS   = 7,
    parameter int MAX_SYMBOLS      = MAX_SYMBOLS_DEF,
    parameter int CNT_W            = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick_in,
    input  logic                   key,
    output logic [MAX_SYMBOLS-1:0] sym_code,
    output logic [2:0]             sym_len,
    output logic                   letter_valid,
    output logic                   letter_err,
    output logic                   word_gap,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] DASH_CNT   = CNT_W'(DASH_UNITS);
    localparam logic [CNT_W-1:0] LETTER_CNT = CNT_W'(LETTER_GAP_UNITS);
    localparam logic [CNT_W-1:0] WORD_CNT   = CNT_W'(WORD_GAP_UNITS);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [2:0]       MAX_LEN    = 3'(MAX_SYMBOLS);

    logic tick_p;
    logic tick_fall_unused;
    logic key_dn;
    logic key_up;

    sync_edge u_tick_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (tick_in),
        .rise (tick_p),
        .fall (tick_fall_unused)
    );

    sync_edge u_key_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (key),
        .rise (key_dn),
        .fall (key_up)
    );

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]       ucnt;
    logic [CNT_W-1:0]       ucnt_inc;
    logic                   key_edge;
    logic                   cnt_step;

    logic [MAX_SYMBOLS-1:0] acc_code;
    logic [2:0]             acc_len;
    logic                   acc_err;
    logic                   acc_full;
    logic                   sym_class;

    logic                   acc_clear;
    logic                   acc_append;
    logic                   emit_letter;
    logic                   emit_word;

    // A key edge wins over a coincident tick: the count clears and the tick is lost.
    assign key_edge  = key_dn | key_up;
    assign cnt_step  = tick_p & ~key_edge & (ucnt != CNT_MAX);
    assign ucnt_inc  = ucnt + CNT_W'(1);
    assign acc_full  = (acc_len >= MAX_LEN);
    assign sym_class = (ucnt >= DASH_CNT) ? SYM_DASH : SYM_DOT;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Gap thresholds are tested on the count being reached this cycle so the
    // registered strobes land in the clk right after the qualifying tick.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_next  = state;
        acc_clear   = 1'b0;
        acc_append  = 1'b0;
        emit_letter = 1'b0;
        emit_word   = 1'b0;
        unique case (state)
            IDLE: begin
                if (key_dn) begin
                    acc_clear  = 1'b1;
                    state_next = MARK;
                end
            end
            MARK: begin
                if (key_up) begin
                    acc_append = 1'b1;
                    state_next = SPACE;
                end
            end
            SPACE: begin
                if (key_dn) begin
                    state_next = MARK;
                end else if (cnt_step && (ucnt_inc == LETTER_CNT)) begin
                    emit_letter = 1'b1;
                    state_next  = GAP;
                end
            end
            GAP: begin
                if (key_dn) begin
                    acc_clear  = 1'b1;
                    state_next = MARK;
                end else if (cnt_step && (ucnt_inc == WORD_CNT)) begin
                    emit_word  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ucnt <= '0;
        end else if (key_edge) begin
            ucnt <= '0;
        end else if (cnt_step) begin
            ucnt <= ucnt_inc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_code <= '0;
            acc_len  <= '0;
            acc_err  <= 1'b0;
        end else if (acc_clear) begin
            acc_code <= '0;
            acc_len  <= '0;
            acc_err  <= 1'b0;
        end else if (acc_append) begin
            if (!acc_full) begin
                acc_code[acc_len] <= sym_class;
                acc_len           <= acc_len + 3'd1;
            end else begin
                acc_err <= 1'b1;
            end
        end
    end

    // Letter outputs only move together with letter_valid and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_code     <= '0;
            sym_len      <= '0;
            letter_err   <= 1'b0;
            letter_valid <= 1'b0;
            word_gap     <= 1'b0;
        end else begin
            letter_valid <= emit_letter;
            word_gap     <= emit_word;
            if (emit_letter) begin
                sym_code   <= acc_code;
                sym_len    <= acc_len;
                letter_err <= acc_err;
            end
        end
    end

endmodule

// File: tb/tb_morse_symbol_framer.sv
// Directed bench for morse_symbol_framer: letters are queued when keyed and
// compared when letter_valid fires; strobe timing is checked around each tick.
module tb_morse_symbol_framer;

    typedef struct packed {
        logic [4:0] code;
        logic [2:0] len;
        logic       err;
    } letter_t;

    logic       clk;
    logic       rst;
    logic       tick_in;
    logic       key;
    logic [4:0] sym_code;
    logic [2:0] sym_len;
    logic       letter_valid;
    logic       letter_err;
    logic       word_gap;
    logic       busy;

    int total;
    int bad;
    int wg_seen;

    letter_t exp_q[$];
    letter_t exp_l;
    logic [8:0] prev_out;

    morse_symbol_framer dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .key          (key),
        .sym_code     (sym_code),
        .sym_len      (sym_len),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
        .word_gap     (word_gap),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_code"}, 32'(sym_code), 32'd0);
        check({tag, "_len"}, 32'(sym_len), 32'd0);
        check({tag, "_err"}, 32'(letter_err), 32'd0);
        check({tag, "_lv"}, 32'(letter_valid), 32'd0);
        check({tag, "_wg"}, 32'(word_gap), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    task automatic key_set(input logic v);
        @(negedge clk);
        key = v;
        repeat (5) @(negedge clk);
    endtask

    // One divided-clock pulse; the strobes must appear on the 4th negedge after the rise.
    task automatic tick(input logic exp_lv, input logic exp_wg, input logic with_press = 1'b0);
        logic [5:0] lvm;
        logic [5:0] wgm;
        lvm = '0;
        wgm = '0;
        @(negedge clk);
        tick_in = 1'b1;
        if (with_press) key = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            lvm[i] = letter_valid;
            wgm[i] = word_gap;
            if (i == 2) tick_in = 1'b0;
        end
        check("lv_timing", 32'(lvm), exp_lv ? 32'h08 : 32'h00);
        check("wg_timing", 32'(wgm), exp_wg ? 32'h08 : 32'h00);
    endtask

    task automatic space3();
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b1, 1'b0);
    endtask

    always @(negedge clk) begin
        if (letter_valid) begin
            check("lv_wg_overlap", 32'(word_gap), 32'd0);
            if (exp_q.size() == 0) begin
                check("letter_extra", 32'd1, 32'd0);
            end else begin
                exp_l = exp_q.pop_front();
                check("letter_code", 32'(sym_code), 32'(exp_l.code));
                check("letter_len", 32'(sym_len), 32'(exp_l.len));
                check("letter_err", 32'(letter_err), 32'(exp_l.err));
            end
        end else if (!rst) begin
            check("out_hold", 32'({sym_code, sym_len, letter_err}), 32'(prev_out));
        end
        if (word_gap) wg_seen++;
        prev_out = {sym_code, sym_len, letter_err};
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        total   = 0;
        bad     = 0;
        wg_seen = 0;
        rst     = 1'b1;
        key     = 1'b0;
        tick_in = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        // E: one dot
        key_set(1'b1);
        check("mark_busy", 32'(busy), 32'd1);
        tick(1'b0, 1'b0);
        key_set(1'b0);
        exp_q.push_back('{code: 5'b00000, len: 3'd1, err: 1'b0});
        space3();

        // A: dot, dash
        key_set(1'b1);
        tick(1'b0, 1'b0);
        key_set(1'b0);
        tick(1'b0, 1'b0);
        key_set(1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        key_set(1'b0);
        exp_q.push_back('{code: 5'b00010, len: 3'd2, err: 1'b0});
        space3();

        // Word gap on the 7th unit after release
        check("gap_busy", 32'(busy), 32'd1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        check("wordgap_busy", 32'(busy), 32'd0);

        // Six dots overflow a five-symbol word
        for (int i = 0; i < 6; i++) begin
            key_set(1'b1);
            tick(1'b0, 1'b0);
            key_set(1'b0);
            if (i < 5) tick(1'b0, 1'b0);
        end
        exp_q.push_back('{code: 5'b00000, len: 3'd5, err: 1'b1});
        space3();
        check("ovf_len_held", 32'(sym_len), 32'd5);
        check("ovf_err_held", 32'(letter_err), 32'd1);

        // Reset mid-letter with the key held
        key_set(1'b1);
        tick(1'b0, 1'b0);
        key_set(1'b0);
        tick(1'b0, 1'b0);
        key_set(1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("held_key_press", 32'(busy), 32'd1);
        tick(1'b0, 1'b0);
        key_set(1'b0);
        exp_q.push_back('{code: 5'b00000, len: 3'd1, err: 1'b0});
        space3();

        // Key press coincident with a tick: that tick is not counted
        tick(1'b0, 1'b0, 1'b1);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        check("coincide_ucnt", 32'(dut.ucnt), 32'd2);
        key_set(1'b0);
        exp_q.push_back('{code: 5'b00000, len: 3'd1, err: 1'b0});
        space3();

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("wordgap_count", 32'(wg_seen), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_symbol_framer.md
# morse_symbol_framer

Downstream consumer of the programmable clock divider's `out` signal in the Morse decipher datapath. Treats each rising edge of the divided clock as one Morse time unit, times the operator key's mark and space durations in those units, and classifies marks as dot or dash. Packs the symbols of one letter into a code word and emits it with a one-cycle valid strobe. Also reports word gaps and letter overflow for the downstream character lookup.

## Interface
- `DASH_UNITS`, 3: a mark of at least this many units is a dash; shorter is a dot.
- `LETTER_GAP_UNITS`, 3: space length, in units since key release, that closes a letter.
- `WORD_GAP_UNITS`, 7: space length, in units since key release, that signals a word gap. Must be greater than `LETTER_GAP_UNITS`.
- `MAX_SYMBOLS`, 5: capacity of the code word.
- `CNT_W`, 4: unit counter width. Must hold `WORD_GAP_UNITS`.

Reset and clock: reset `rst`, asynchronous, active-high; clock `clk`.

- `clk` input 1: system clock.
- `rst` input 1: asynchronous active-high reset.
- `tick_in` input 1: divided clock from the divider. Asynchronous to use, so it is synchronized.
- `key` input 1: operator key, 1 = pressed. Asynchronous, so it is synchronized.
- `sym_code` output `MAX_SYMBOLS`: symbol i of the letter is in bit i (first symbol is in bit 0). 0 = dot, 1 = dash. Unused bits are 0.
- `sym_len` output 3: number of symbols in `sym_code`.
- `letter_valid` output 1: one-cycle strobe; `sym_code`, `sym_len` and `letter_err` are valid.
- `letter_err` output 1: the letter overflowed `MAX_SYMBOLS`.
- `word_gap` output 1: one-cycle strobe at the word-gap boundary.
- `busy` output 1: high in every state except IDLE.

## Operation
- Synchronization:
  - `tick_in` passes through a 2-FF synchronizer. A rising edge gives `tick_p`, a one-clk pulse.
  - `key` passes through a 2-FF synchronizer. Its edges give `key_dn` and `key_up`.
  - All synchronizer flops reset to 0.
- Unit counter: `ucnt` (`CNT_W` bits). It increments on `tick_p`, saturates at all-ones, and clears on any key edge.
- Symbol accumulator: `acc_code` and `acc_len`.
- States:
  - IDLE: on `key_dn`, clear `acc_code`, `acc_len` and the error flag, then go to MARK.
  - MARK: on `key_up`, classify the mark. Dash if `ucnt >= DASH_UNITS`, otherwise dot; a mark of 0 units is a dot. Append the symbol and go to SPACE.
    - Append when `acc_len < MAX_SYMBOLS`: write the bit at index `acc_len`, then increment `acc_len`.
    - Append when full: drop the symbol and set the error flag.
  - SPACE: if `key_dn` arrives before `ucnt` reaches `LETTER_GAP_UNITS`, go to MARK and keep the accumulator. When `ucnt == LETTER_GAP_UNITS`:
    - copy `acc_code`, `acc_len` and the error flag to the outputs;
    - pulse `letter_valid`;
    - go to GAP without clearing `ucnt`.
  - GAP: on `key_dn`, clear the accumulator and go to MARK. When `ucnt == WORD_GAP_UNITS`, pulse `word_gap` and go to IDLE.
- Simultaneous events: if a key edge and `tick_p` arrive in the same cycle, the key edge wins. `ucnt` clears and that tick is not counted.
- Output hold: `sym_code`, `sym_len` and `letter_err` hold their values until the next `letter_valid`.

## Timing
- Reset:
  - state goes to IDLE;
  - all outputs go to 0;
  - counters, accumulator and synchronizers go to 0.
- Reset mid-letter discards the partial letter. A key still held after reset deasserts is seen as a new press.
- Latency, pin to pulse: a pin edge on `key` or `tick_in` appears as an internal pulse 3 clk later (2 sync stages plus the edge register).
- Latency, pulse to outputs: `letter_valid` and `word_gap` are registered. They assert in the clk after the qualifying `tick_p` and last exactly 1 clk.
- Output stability: `sym_code`, `sym_len` and `letter_err` change only in the same cycle `letter_valid` asserts.
- `letter_valid` and `word_gap` are never high in the same cycle.

## Structure
- Package `morse_pkg`:
  - state enum (IDLE, MARK, SPACE, GAP);
  - `SYM_DOT` = 0 and `SYM_DASH` = 1;
  - default `MAX_SYMBOLS`.
- Sub-module `sync_edge`: 2-FF synchronizer plus rise/fall edge detect. Instantiate it once for `tick_in` and once for `key`.
- The top level holds the FSM, unit counter and accumulator.

## Test plan
All scenarios use the default parameters.
- Dot for 1 tick, release, idle for 3 ticks: one `letter_valid` with `sym_code` = 00000, `sym_len` = 1, `letter_err` = 0 (E).
- Dot 1 tick, space 1 tick, dash 3 ticks, release, space 3 ticks: `sym_code` = 00010, `sym_len` = 2 (A).
- After a letter, hold the key released: `letter_valid` after the 3rd tick. `word_gap` asserts for 1 clk after the 7th tick, then `busy` = 0.
- Six dots with 1-tick spaces, then a 3-tick space: `sym_len` = 5, `sym_code` = 00000, `letter_err` = 1.
- Assert `rst` after two symbols while the key is held: all outputs 0 at once. Release after 1 tick, then space 3 ticks: `sym_len` = 1, `sym_code` = 00000.
- `key` rising edge coincident with `tick_p`, held for exactly 2 further ticks, then released: the first tick is not counted, `ucnt` = 2, and the symbol is a dot.
